// File: rtl/nibble_serial_adder_if.sv
// Operand and result handshakes for nibble_serial_adder.
// The sub field exists only with NIBBLE_SERIAL_ADDER_SUB_EN.
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, in1, in2, cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, in1, in2, cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Wide adder built from one 4-bit ripple slice, one nibble per clock.
// Define NIBBLE_SERIAL_ADDER_SUB_EN to add the sub (in1-in2) request.
module RCA_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;

    assign c[0] = ci;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign co = c[4];
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input logic                  clock,
    input logic                  reset,
    nibble_serial_adder_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [3:0]    s_nib;
    logic          s_co;

    RCA_4b u_slice (
        .a  (a_nib),
        .b  (b_nib),
        .ci (carry_q),
        .s  (s_nib),
        .co (s_co)
    );

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in1;
                    b_d     = bus.in2;
                    carry_d = bus.cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
                    if (bus.sub) begin
                        b_d     = ~bus.in2;
                        carry_d = 1'b1;
                    end
`endif
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IW'(i)) sum_d[4*i +: 4] = s_nib;
                end
                carry_d = s_co;
                if (idx_q == LAST) begin
                    // B is already inverted when subtracting
                    ovf_d   = (a_q[W-1] == b_q[W-1]) &&
                              (s_nib[3] != a_q[W-1]);
                    cout_d  = s_co;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !reset;
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4).
// Directed table, corner sequences and random ops vs. an arithmetic model.
module tb_nibble_serial_adder;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    nibble_serial_adder_if #(.NIBBLES(N)) bus ();

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sb;
        logic [W-1:0] e_sum;
        logic         e_cout;
        logic         e_ovf;
    } vec_t;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic sb);
        bus.in_valid = 1'b1;
        bus.in1      = a;
        bus.in2      = b;
        bus.cin      = ci;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        bus.sub      = sb;
`else
        if (sb) $display("sub ignored in this build");
`endif
    endtask

    // Accept an op and wait for out_valid; leaves the block in DONE.
    task automatic start_op(input string nm, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic ci,
                            input logic sb);
        int n;
        drive(a, b, ci, sb);
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        chk({nm, " in_ready"}, 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 20) begin
            chk({nm, " in_ready_busy"}, 64'(bus.in_ready), 64'd0);
            tick();
            if (!bus.out_valid) n++;
        end
        chk({nm, " latency"}, 64'(n), 64'(N));
    endtask

    task automatic finish_op(input string nm, input int hold);
        for (int i = 0; i < hold; i++) tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({nm, " out_valid_drop"}, 64'(bus.out_valid), 64'd0);
        chk({nm, " idle_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic check_result(input string nm, input logic [W-1:0] es,
                                input logic ec, input logic eo);
        chk({nm, " sum"}, 64'(bus.sum), 64'(es));
        chk({nm, " cout"}, 64'(bus.cout), 64'(ec));
        chk({nm, " ovf"}, 64'(bus.ovf), 64'(eo));
    endtask

    // Reference: whole-word arithmetic on 17-bit values.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic sb,
                         output logic [W-1:0] s, output logic c,
                         output logic o);
        logic [W:0] full;
        longint sa, sb2, sr;
        sa = longint'($signed(a));
        sb2 = longint'($signed(b));
        if (sb) begin
            full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            sr = sa - sb2;
        end else begin
            full = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
            sr = sa + sb2 + longint'(ci);
        end
        s = full[W-1:0];
        c = full[W];
        o = (sr > 32767) || (sr < -32768);
    endtask

    vec_t vecs[$];

    initial begin
        logic [W-1:0] held, ra, rb, es;
        logic rc, rs, ec, eo;
        bit sub_en;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        sub_en = 1'b1;
        bus.sub = 1'b0;
`else
        sub_en = 1'b0;
`endif
        bus.in_valid  = 1'b0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;

        vecs.push_back('{"basic", 16'h1234, 16'h0FCD, 1'b0, 1'b0,
                         16'h2201, 1'b0, 1'b0});
        vecs.push_back('{"ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0,
                         16'h0000, 1'b1, 1'b0});
        vecs.push_back('{"sovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0,
                         16'h8000, 1'b0, 1'b1});
        vecs.push_back('{"negovf", 16'h8000, 16'h8000, 1'b0, 1'b0,
                         16'h0000, 1'b1, 1'b1});
        if (sub_en) begin
            vecs.push_back('{"sub1", 16'h0005, 16'h0007, 1'b1, 1'b1,
                             16'hFFFE, 1'b0, 1'b0});
            vecs.push_back('{"sub2", 16'h8000, 16'h0001, 1'b0, 1'b1,
                             16'h7FFF, 1'b1, 1'b1});
        end

        tick();
        tick();
        chk("rst in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst out_valid", 64'(bus.out_valid), 64'd0);
        check_result("rst", '0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        chk("post_rst in_ready", 64'(bus.in_ready), 64'd1);

        foreach (vecs[i]) begin
            start_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].ci,
                     vecs[i].sb);
            check_result(vecs[i].name, vecs[i].e_sum, vecs[i].e_cout,
                         vecs[i].e_ovf);
            finish_op(vecs[i].name, 0);
        end

        start_op("bp", 16'h1111, 16'h2222, 1'b0, 1'b0);
        held = bus.sum;
        chk("bp first", 64'(held), 64'h3333);
        drive(16'h4000, 16'h0123, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp sum_hold", 64'(bus.sum), 64'(held));
        end
        finish_op("bp", 0);
        start_op("bp2", 16'h4000, 16'h0123, 1'b1, 1'b0);
        check_result("bp2", 16'h4124, 1'b0, 1'b0);
        finish_op("bp2", 0);

        drive(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("mid_rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst in_ready", 64'(bus.in_ready), 64'd0);
        check_result("mid_rst", '0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        chk("mid_rst ready_after", 64'(bus.in_ready), 64'd1);
        start_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0);
        check_result("after_rst", 16'h0002, 1'b0, 1'b0);
        finish_op("after_rst", 0);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rs = sub_en ? 1'($urandom) : 1'b0;
            model(ra, rb, rc, rs, es, ec, eo);
            start_op("rand", ra, rb, rc, rs);
            check_result("rand", es, ec, eo);
            finish_op("rand", int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide adder that feeds the team's 4-bit ripple-carry slice (`RCA_4b`) one nibble per clock and assembles the full-width result. Operands arrive on a valid/ready handshake, and the carry is registered between nibbles. The result leaves on a second valid/ready handshake. The block trades latency for area: one `RCA_4b` instance serves any operand width.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices. Operand width is W = 4*NIBBLES; legal range 1..16.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand bundle valid.
- `in_ready`  out  1  block can accept an operand bundle.
- `in1`  in  W  operand A.
- `in2`  in  W  operand B.
- `cin`  in  1  carry-in for the least-significant nibble.
- `sub`  in  1  subtract request; present only with `SUB_EN`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  W  result.
- `cout`  out  1  carry out of the most-significant nibble.
- `ovf`  out  1  two's-complement signed overflow.

## Operation
- The FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE**
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid`&&`in_ready`: latch A←`in1` and B←`in2` (B←~`in2` if subtracting), carry←`cin` (1 if subtracting), idx←0, then go to RUN.
- **RUN**
  - `in_ready`=0, `out_valid`=0.
  - Each cycle, `RCA_4b` adds A[idx], B[idx] and carry.
  - The slice sum is written to result nibble idx, and carry←slice cout.
  - If idx==NIBBLES-1: latch `ovf` = (A[W-1]==B[W-1]) && (slice sum MSB != A[W-1]), latch `cout`, go to DONE. Otherwise idx←idx+1.
- **DONE**
  - `out_valid`=1, `in_ready`=0.
  - `sum`, `cout` and `ovf` are stable and held while `out_ready`=0.
  - On `out_ready`, go to IDLE.
- Arithmetic is modulo 2^W. `cout` is the true unsigned carry; with subtraction, `cout`=1 means no borrow.
- idx is a ceil(log2(NIBBLES))-bit counter and never wraps past NIBBLES-1.
- For NIBBLES=1, RUN lasts exactly one cycle.
- Inputs are ignored outside IDLE; `in_valid` asserted in RUN or DONE is neither captured nor lost silently. The producer must hold its inputs until `in_ready` is seen.

## Timing
- Reset values: `in_ready`=0 while `reset`=1, then 1 on the first cycle after reset deasserts. `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0.
- `reset` asserted in any state (including mid-RUN or DONE) discards the operation. The following cycle is IDLE with all outputs at their reset values.
- Latency: accept at edge k; RUN occupies edges k+1..k+NIBBLES; `out_valid` rises after edge k+NIBBLES.
- Throughput: at most one operation per NIBBLES+2 cycles. No new accept is possible in the same cycle as the result handshake.
- `in_ready` and `out_valid` are registered state decodes with no combinational path from `in_valid`/`out_ready`.
- `sum`, `cout` and `ovf` come from registers and only change in RUN.

## Configuration
- `NIBBLE_SERIAL_ADDER_SUB_EN`
  - **Defined:** the `sub` port exists.
    - `sub`=1 at accept computes `in1`-`in2`: B is inverted, initial carry is 1, and `cin` is ignored.
    - `sub`=0 behaves as plain addition.
  - **Undefined:** no `sub` port; the block always computes `in1`+`in2`+`cin`, and the inversion logic is absent.

## Test plan
All cases use NIBBLES=4.
- **Basic add:** 16'h1234 + 16'h0FCD, `cin`=0 → `sum`=16'h2201, `cout`=0, `ovf`=0, with `out_valid` rising 4 edges after accept.
- **Full ripple:** 16'hFFFF + 16'h0000, `cin`=1 → `sum`=16'h0000, `cout`=1, `ovf`=0; carry crosses every nibble boundary.
- **Signed overflow:** 16'h7FFF + 16'h0001, `cin`=0 → `sum`=16'h8000, `cout`=0, `ovf`=1.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE while driving `in_valid`=1 with new operands.
  - `out_valid` and `sum` are held, and `in_ready`=0.
  - The new operands are accepted only after `out_ready` and the return to IDLE.
- **Reset mid-operation:** assert `reset` after 2 RUN cycles of 16'hAAAA + 16'h5555.
  - The next cycle shows `out_valid`=0, `sum`=0, `cout`=0 and `ovf`=0, with `in_ready`=0 while `reset` is high and 1 on the first cycle after it deasserts.
  - A following 16'h0001 + 16'h0001 yields 16'h0002.
- **Subtract (`NIBBLE_SERIAL_ADDER_SUB_EN` defined):** 16'h0005 - 16'h0007 with `sub`=1 → `sum`=16'hFFFE, `cout`=0, `ovf`=0.
  - 16'h8000 - 16'h0001 → `sum`=16'h7FFF, `ovf`=1.
